dd_print_scheduler: RTL and testbench

- Shares the single 16-bit binary-to-BCD/ASCII converter (double-dabble unit) between N requesters.
- Sequences each conversion and streams the resulting decimal ASCII characters, most significant first, onto one character-output handshake (UART TX / console FIFO).
- Sits between CPU-side print requesters and the converter plus the character sink.

---
 rtl/dd_print_scheduler.sv | 143 ++++++++++++++
 tb/tb_dd_print_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dd_print_scheduler.sv
// dd_print_scheduler: shares one double-dabble converter between N_REQ print
// requesters and streams the decimal ASCII result, most significant digit
// first, onto a valid/ready character sink, optionally followed by a terminator.
module dd_print_scheduler #(
  parameter int         N_REQ       = 2,
  parameter bit         SUPPRESS_LZ = 1'b1,
  parameter bit         TERM_EN     = 1'b1,
  parameter logic [7:0] TERM_CHAR   = 8'h0A
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  req_value,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic                 dd_start,
  output logic [15:0]          dd_data,
  input  logic                 dd_busy,
  input  logic [39:0]          dd_digits,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE, START, WAIT_HI, CONVERT, SETTLE, SEND, TERM, FINISH
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] ptr;
  logic [PW-1:0] winner;
  logic          found;
  logic [1:0]    wd_cnt;
  logic [2:0]    idx;
  logic [2:0]    first_idx;
  logic [7:0]    hold [5];

  // Round-robin search starting one past the last served requester.
  always_comb begin
    int cand;
    cand   = 0;
    found  = 1'b0;
    winner = ptr;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && req[cand[PW-1:0]]) begin
        found  = 1'b1;
        winner = cand[PW-1:0];
      end
    end
  end

  // First digit to send: the highest nonzero digit when suppressing, ones digit at minimum.
  always_comb begin
    first_idx = 3'd4;
    if (SUPPRESS_LZ) begin
      first_idx = 3'd0;
      for (int k = 1; k <= 4; k++) begin
        if (dd_digits[8*k +: 8] != 8'h30) first_idx = 3'(k);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and handshake outputs; everything is decoded from the state so reset clears it at once.
  always_comb begin
    state_next = state;
    dd_start   = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    done       = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (found) state_next = START;
      START: begin
        dd_start   = 1'b1;
        state_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (dd_busy)              state_next = CONVERT;
        else if (wd_cnt == 2'd2)  state_next = SETTLE;
      end
      CONVERT: if (!dd_busy) state_next = SETTLE;
      SETTLE:  state_next = SEND;
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = hold[idx];
        if (tx_ready && idx == 3'd0) state_next = TERM_EN ? TERM : FINISH;
      end
      TERM: begin
        tx_valid = 1'b1;
        tx_data  = TERM_CHAR;
        if (tx_ready) state_next = FINISH;
      end
      FINISH: begin
        done[ptr]  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture, watchdog, digit holding register and character index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr     <= PW'(N_REQ - 1);
      dd_data <= 16'h0000;
      grant   <= '0;
      wd_cnt  <= 2'd0;
      idx     <= 3'd0;
      for (int k = 0; k < 5; k++) hold[k] <= 8'h00;
    end else begin
      grant <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            ptr           <= winner;
            dd_data       <= req_value[16*winner +: 16];
            grant[winner] <= 1'b1;
          end
        end
        START:   wd_cnt <= 2'd0;
        WAIT_HI: wd_cnt <= wd_cnt + 2'd1;
        SETTLE: begin
          for (int k = 0; k < 5; k++) hold[k] <= dd_digits[8*k +: 8];
          idx <= first_idx;
        end
        SEND: if (tx_ready && idx != 3'd0) idx <= idx - 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dd_print_scheduler.sv
// Testbench for dd_print_scheduler: two instances (leading-zero suppression with
// terminator, and fixed five digits without terminator) share a behavioural
// converter; output strings and grant order come from a decimal/round-robin model.
`timescale 1ns/1ps
module tb_dd_print_scheduler;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [1:0]  req_a, req_b, grant_a, grant_b, done_a, done_b;
  logic [31:0] req_value_a, req_value_b;
  logic        dd_start_a, dd_start_b;
  logic [15:0] dd_data_a, dd_data_b;
  logic [7:0]  tx_data_a, tx_data_b;
  logic        tx_valid_a, tx_valid_b, tx_ready_a, tx_ready_b, busy_a, busy_b;
  logic        dd_busy   = 1'b0;
  logic [39:0] dd_digits = {5{8'h30}};
  logic        conv_absent;
  int          conv_phase = 0;
  int          conv_operand = 0;

  int checks = 0;
  int errors = 0;
  int rr_ptr [2];
  int last_conv;
  logic [7:0] exp_q [$];

  dd_print_scheduler #(.N_REQ(2), .SUPPRESS_LZ(1'b1), .TERM_EN(1'b1), .TERM_CHAR(8'h0A)) dut_a (
    .clk(clk), .reset_n(reset_n), .req(req_a), .req_value(req_value_a),
    .grant(grant_a), .done(done_a), .dd_start(dd_start_a), .dd_data(dd_data_a),
    .dd_busy(dd_busy), .dd_digits(dd_digits), .tx_data(tx_data_a),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .busy(busy_a)
  );

  dd_print_scheduler #(.N_REQ(2), .SUPPRESS_LZ(1'b0), .TERM_EN(1'b0), .TERM_CHAR(8'h0A)) dut_b (
    .clk(clk), .reset_n(reset_n), .req(req_b), .req_value(req_value_b),
    .grant(grant_b), .done(done_b), .dd_start(dd_start_b), .dd_data(dd_data_b),
    .dd_busy(dd_busy), .dd_digits(dd_digits), .tx_data(tx_data_b),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .busy(busy_b)
  );

  function automatic logic [39:0] to_ascii(input int v);
    logic [39:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < 5; k++) begin
      r[8*k +: 8] = 8'(8'h30 + (v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Converter model: busy after the start edge, low after 16 more edges, digits one edge later.
  always @(posedge clk) begin
    if (dd_start_a || dd_start_b) begin
      if (!conv_absent) begin
        conv_phase   <= 1;
        dd_busy      <= 1'b1;
        conv_operand <= int'(dd_start_a ? dd_data_a : dd_data_b);
      end
    end else if (conv_phase >= 1 && conv_phase <= 15) begin
      conv_phase <= conv_phase + 1;
    end else if (conv_phase == 16) begin
      dd_busy    <= 1'b0;
      conv_phase <= 17;
    end else if (conv_phase == 17) begin
      dd_digits  <= to_ascii(conv_operand);
      conv_phase <= 0;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void build_expected(input int value, input bit suppress, input bit term);
    int pow10 [5];
    pow10 = '{10000, 1000, 100, 10, 1};
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h30 + (value / pow10[i]) % 10));
    if (suppress) while (exp_q.size() > 1 && exp_q[0] == 8'h30) void'(exp_q.pop_front());
    if (term) exp_q.push_back(8'h0A);
  endfunction

  function automatic int predict_winner(input int sel, input logic [1:0] mask);
    for (int off = 1; off <= 2; off++) begin
      int cand;
      cand = (rr_ptr[sel] + off) % 2;
      if (mask[cand]) return cand;
    end
    return -1;
  endfunction

  task automatic set_ready(input int sel, input logic r);
    if (sel == 1) tx_ready_b = r;
    else          tx_ready_a = r;
  endtask

  task automatic run_txn(input int sel, input int exp_winner, input int value,
                         input int ready_mode, input bit drop_req, input string tag);
    logic [1:0] g, d;
    logic       s_val, r, prev_stall, last_accept;
    logic [7:0] s_data, prev_data;
    logic [7:0] got [$];
    int         latency, valid_cycles, gaps, phase, conv_value, n;
    bit         saw_grant, saw_valid, saw_done;

    saw_grant = 1'b0;
    g = 2'b00;
    for (int i = 0; i < 8 && !saw_grant; i++) begin
      @(posedge clk); #1;
      g = (sel == 1) ? grant_b : grant_a;
      if (g != 2'b00) saw_grant = 1'b1;
    end
    check_output($sformatf("%s grant_seen", tag), 32'(saw_grant), 32'd1);
    if (!saw_grant) return;
    check_output($sformatf("%s grant", tag), 32'(g), 32'(1 << exp_winner));
    check_output($sformatf("%s dd_start", tag), 32'((sel == 1) ? dd_start_b : dd_start_a), 32'd1);
    check_output($sformatf("%s dd_data", tag), 32'((sel == 1) ? dd_data_b : dd_data_a), 32'(value));
    check_output($sformatf("%s busy", tag), 32'((sel == 1) ? busy_b : busy_a), 32'd1);
    rr_ptr[sel] = exp_winner;
    if (drop_req) begin
      if (sel == 1) req_b = 2'b00;
      else          req_a = 2'b00;
    end
    if (conv_absent) conv_value = last_conv;
    else begin
      conv_value = value;
      last_conv  = value;
    end

    @(posedge clk); #1;
    check_output($sformatf("%s grant_pulse_end", tag), 32'((sel == 1) ? grant_b : grant_a), 32'd0);
    check_output($sformatf("%s start_pulse_end", tag), 32'((sel == 1) ? dd_start_b : dd_start_a), 32'd0);

    latency = 1; valid_cycles = 0; gaps = 0; phase = 0;
    saw_valid = 1'b0; saw_done = 1'b0; prev_stall = 1'b0; last_accept = 1'b0;
    prev_data = 8'h00;
    got.delete();
    for (int i = 0; i < 200 && !saw_done; i++) begin
      s_val  = (sel == 1) ? tx_valid_b : tx_valid_a;
      s_data = (sel == 1) ? tx_data_b  : tx_data_a;
      d      = (sel == 1) ? done_b     : done_a;
      if (d != 2'b00) begin
        saw_done = 1'b1;
        check_output($sformatf("%s done", tag), 32'(d), 32'(1 << exp_winner));
        check_output($sformatf("%s done_after_accept", tag), 32'(last_accept), 32'd1);
        check_output($sformatf("%s valid_in_done", tag), 32'(s_val), 32'd0);
      end else begin
        if (prev_stall) begin
          check_output($sformatf("%s stall_valid", tag), 32'(s_val), 32'd1);
          check_output($sformatf("%s stall_data", tag), 32'(s_data), 32'(prev_data));
        end
        if (ready_mode == 1)      r = (phase % 3 == 0);
        else if (ready_mode == 2) r = ($urandom_range(0, 3) != 0);
        else                      r = 1'b1;
        set_ready(sel, r);
        if (s_val) begin
          if (!saw_valid) begin
            saw_valid = 1'b1;
            check_output($sformatf("%s latency", tag), 32'(latency), conv_absent ? 32'd5 : 32'd19);
          end
          valid_cycles++;
          phase++;
          if (r) got.push_back(s_data);
          prev_stall  = !r;
          prev_data   = s_data;
          last_accept = r;
        end else begin
          if (saw_valid) gaps++;
          else           latency++;
          prev_stall  = 1'b0;
          last_accept = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    set_ready(sel, 1'b1);
    check_output($sformatf("%s done_seen", tag), 32'(saw_done), 32'd1);

    build_expected(conv_value, sel == 0, sel == 0);
    check_output($sformatf("%s char_count", tag), 32'(got.size()), 32'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check_output($sformatf("%s char%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    check_output($sformatf("%s valid_gaps", tag), 32'(gaps), 32'd0);
    if (ready_mode == 0)
      check_output($sformatf("%s one_char_per_cycle", tag), 32'(valid_cycles), 32'(exp_q.size()));

    @(posedge clk); #1;
    check_output($sformatf("%s idle_busy", tag), 32'((sel == 1) ? busy_b : busy_a), 32'd0);
  endtask

  task automatic apply_stimulus(input int sel, input logic [1:0] mask, input logic [15:0] v0,
                                input logic [15:0] v1, input int ready_mode, input bit drop_req,
                                input string tag);
    int w;
    if (sel == 1) begin
      req_b = mask; req_value_b = {v1, v0};
    end else begin
      req_a = mask; req_value_a = {v1, v0};
    end
    w = predict_winner(sel, mask);
    run_txn(sel, w, int'((w == 1) ? v1 : v0), ready_mode, drop_req, tag);
  endtask

  initial begin
    bit          seen;
    int          sel;
    logic [1:0]  mask;
    logic [15:0] v0, v1;

    reset_n = 1'b0;
    req_a = 2'b00; req_b = 2'b00; req_value_a = '0; req_value_b = '0;
    tx_ready_a = 1'b1; tx_ready_b = 1'b1; conv_absent = 1'b0;
    rr_ptr = '{1, 1};
    last_conv = 0;
    $display("[TB] starting dd_print_scheduler bench");

    repeat (3) @(posedge clk);
    #1;
    check_output("reset grant", 32'(grant_a), 32'd0);
    check_output("reset done", 32'(done_a), 32'd0);
    check_output("reset dd_start", 32'(dd_start_a), 32'd0);
    check_output("reset dd_data", 32'(dd_data_a), 32'd0);
    check_output("reset tx_data", 32'(tx_data_a), 32'd0);
    check_output("reset tx_valid", 32'(tx_valid_a), 32'd0);
    check_output("reset busy_a", 32'(busy_a), 32'd0);
    check_output("reset busy_b", 32'(busy_b), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    apply_stimulus(0, 2'b01, 16'd12345, 16'd0, 0, 1'b1, "v12345");
    apply_stimulus(0, 2'b01, 16'd0, 16'd0, 0, 1'b1, "v0");
    apply_stimulus(0, 2'b10, 16'd0, 16'd42, 0, 1'b1, "v42");
    apply_stimulus(1, 2'b01, 16'd42, 16'd0, 0, 1'b1, "b_v42");
    apply_stimulus(1, 2'b10, 16'd0, 16'd0, 0, 1'b1, "b_v0");

    apply_stimulus(0, 2'b11, 16'd7, 16'd9, 0, 1'b0, "rr1");
    apply_stimulus(0, 2'b11, 16'd7, 16'd9, 0, 1'b0, "rr2");
    apply_stimulus(0, 2'b11, 16'd7, 16'd9, 0, 1'b0, "rr3");
    apply_stimulus(0, 2'b11, 16'd7, 16'd9, 0, 1'b1, "rr4");

    apply_stimulus(0, 2'b01, 16'd65535, 16'd0, 1, 1'b1, "v65535_stall");

    for (int i = 0; i < 6; i++) begin
      sel  = int'($urandom_range(0, 1));
      mask = 2'($urandom_range(1, 3));
      v0   = 16'($urandom_range(0, 65535));
      v1   = 16'($urandom_range(0, 999));
      apply_stimulus(sel, mask, v0, v1, 2, 1'b1, $sformatf("rand%0d", i));
    end

    conv_absent = 1'b1;
    apply_stimulus(0, 2'b01, 16'd321, 16'd0, 0, 1'b1, "watchdog");
    conv_absent = 1'b0;

    req_a = 2'b01; req_value_a = {16'd0, 16'd12345}; tx_ready_a = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      if (tx_valid_a && tx_data_a == 8'h31) seen = 1'b1;
    end
    check_output("rst reach_digit4", 32'(seen), 32'd1);
    req_a = 2'b00;
    @(posedge clk); #1;
    tx_ready_a = 1'b0;
    check_output("rst digit3_shown", 32'(tx_data_a), 32'h32);
    #2 reset_n = 1'b0;
    #1;
    check_output("rst async tx_valid", 32'(tx_valid_a), 32'd0);
    check_output("rst async busy", 32'(busy_a), 32'd0);
    check_output("rst async done", 32'(done_a), 32'd0);
    check_output("rst async tx_data", 32'(tx_data_a), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tx_ready_a = 1'b1;
    rr_ptr = '{1, 1};
    last_conv = 12345;
    apply_stimulus(0, 2'b11, 16'd500, 16'd600, 0, 1'b1, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
